// File: rtl/relu_stream_tx.sv
// -----------------------------------------------------------------------------
// relu_stream_tx
//
// Producer side of the relu_valid/relu_data stream that feeds maxpool.
// Signed convolution results are rectified (negative -> 0) and saturated to an
// unsigned DATA_W-bit value on the way into a small FIFO. The FIFO is drained
// one entry at a time as single-cycle relu_valid strobes spaced at least GAP
// cycles apart. maxpool cannot stall us, so every bit of pacing happens here.
//
// Ports
//   clk         in   system clock, rising edge
//   rstn        in   asynchronous active-low reset
//   conv_valid  in   conv_data is valid this cycle
//   conv_data   in   CONV_W-bit two's-complement accumulator result
//   conv_ready  out  FIFO has room (combinational, count != DEPTH)
//   relu_valid  out  registered single-cycle strobe to maxpool
//   relu_data   out  registered pixel, forced to 0 when relu_valid is 0
//   relu_eol    out  registered, high with relu_valid on the last pixel of a row
//   ovf_err     out  sticky, set when a conv_valid beat was dropped on a full FIFO
// -----------------------------------------------------------------------------
module relu_stream_tx #(
   parameter int CONV_W       = 26,
   parameter int DATA_W       = 22,
   parameter int DEPTH        = 16,
   parameter int GAP          = 4,
   parameter int reludata_num = 6
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              conv_valid,
   input  logic [CONV_W-1:0] conv_data,
   output logic              conv_ready,
   output logic              relu_valid,
   output logic [DATA_W-1:0] relu_data,
   output logic              relu_eol,
   output logic              ovf_err
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int COLW = (reludata_num > 1) ? $clog2(reludata_num) : 1;

   // ReLU followed by unsigned saturation. The sign bit selects zero; any set
   // bit between the sign and the kept field means the value exceeds the
   // DATA_W range and clamps to all ones.
   function automatic logic [DATA_W-1:0] relu_sat(input logic [CONV_W-1:0] x);
      logic [DATA_W-1:0] r;
      if (x[CONV_W-1]) begin
         r = {DATA_W{1'b0}};
      end else if (|x[CONV_W-2:DATA_W]) begin
         r = {DATA_W{1'b1}};
      end else begin
         r = x[DATA_W-1:0];
      end
      return r;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [COLW-1:0]   col_q, col_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              eol_q, eol_d;
   logic              ovf_q, ovf_d;
   logic              wr_en_s;
   logic              pop_s;
   logic              full_s;

   assign full_s     = (count_q == CW'(DEPTH));
   assign conv_ready = ~full_s;
   assign wr_en_s    = conv_valid & ~full_s;
   assign pop_s      = (count_q != {CW{1'b0}}) & (gap_q == {GW{1'b0}});

   assign relu_valid = valid_q;
   assign relu_data  = data_q;
   assign relu_eol   = eol_q;
   assign ovf_err    = ovf_q;

   // Next-state logic for pointers, occupancy, pacing, row position and outputs.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      gap_d    = gap_q;
      col_d    = col_q;
      valid_d  = 1'b0;
      data_d   = {DATA_W{1'b0}};
      eol_d    = 1'b0;
      ovf_d    = ovf_q;

      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      // Occupancy only moves when exactly one of write/pop happens.
      case ({wr_en_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         valid_d  = 1'b1;
         data_d   = mem_q[rd_ptr_q];
         gap_d    = GW'(GAP - 1);
         if (col_q == COLW'(reludata_num - 1)) begin
            col_d = {COLW{1'b0}};
            eol_d = 1'b1;
         end else begin
            col_d = col_q + COLW'(1);
            eol_d = 1'b0;
         end
      end else if (gap_q != {GW{1'b0}}) begin
         // Pacing timer keeps running even while the FIFO is empty.
         gap_d = gap_q - GW'(1);
      end else begin
         gap_d = gap_q;
      end

      if (conv_valid & full_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control and output registers; reset discards everything buffered.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         gap_q    <= {GW{1'b0}};
         col_q    <= {COLW{1'b0}};
         valid_q  <= 1'b0;
         data_q   <= {DATA_W{1'b0}};
         eol_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         col_q    <= col_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         eol_q    <= eol_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers gate all reads.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= relu_sat(conv_data);
      end
   end

endmodule

// File: tb/tb_relu_stream_tx.sv
module tb_relu_stream_tx;

   localparam int CONV_W = 26;
   localparam int DATA_W = 22;
   localparam int DEPTH  = 16;
   localparam int GAP    = 4;
   localparam int ROWN   = 6;
   localparam int MAXV   = 4194303;

   logic              clk = 1'b0;
   logic              rstn;
   logic              conv_valid;
   logic [CONV_W-1:0] conv_data;
   logic              conv_ready;
   logic              relu_valid;
   logic [DATA_W-1:0] relu_data;
   logic              relu_eol;
   logic              ovf_err;

   relu_stream_tx #(
      .CONV_W(CONV_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP(GAP), .reludata_num(ROWN)
   ) dut (
      .clk(clk), .rstn(rstn), .conv_valid(conv_valid), .conv_data(conv_data),
      .conv_ready(conv_ready), .relu_valid(relu_valid), .relu_data(relu_data),
      .relu_eol(relu_eol), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue, pacing as a countdown,
   // row position as a running pop count.
   int mq[$];
   int mgap     = 0;
   int mpops    = 0;
   bit movf     = 1'b0;
   bit mpop_last = 1'b0;
   int max_fill = 0;

   // Scoreboard of expected transmitted pixels.
   int exp_d[$];
   bit exp_e[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int sat(input logic [CONV_W-1:0] d);
      int x;
      x = $signed(d);
      if (x < 0) return 0;
      else if (x > MAXV) return MAXV;
      else return x;
   endfunction

   task automatic model_clear();
      mq.delete();
      exp_d.delete();
      exp_e.delete();
      mgap = 0;
      mpops = 0;
      movf = 1'b0;
      mpop_last = 1'b0;
   endtask

   // Advance the model by one clock edge given the inputs presented to it.
   task automatic model_edge(input bit v, input logic [CONV_W-1:0] d);
      bit acc;
      bit pop;
      int h;
      acc = v && (mq.size() < DEPTH);
      pop = (mq.size() != 0) && (mgap == 0);
      if (pop) begin
         h = mq.pop_front();
         mpops++;
         exp_d.push_back(h);
         exp_e.push_back((mpops % ROWN) == 0);
         mgap = GAP - 1;
      end else if (mgap > 0) begin
         mgap--;
      end
      if (acc) mq.push_back(sat(d));
      else if (v) movf = 1'b1;
      mpop_last = pop;
      if (mq.size() > max_fill) max_fill = mq.size();
   endtask

   task automatic step(input bit v, input logic [CONV_W-1:0] d);
      conv_valid = v;
      conv_data  = d;
      @(posedge clk);
      model_edge(v, d);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (mq.size() != 0 || exp_d.size() != 0); i++) step(1'b0, '0);
      repeat (GAP) step(1'b0, '0);
      chk("drain_model_empty", mq.size(), 0);
      chk("drain_sb_empty", exp_d.size(), 0);
   endtask

   // Monitor: compares DUT outputs against the model after every edge.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         chk("conv_ready", conv_ready, (mq.size() != DEPTH));
         chk("ovf_err", ovf_err, movf);
         chk("relu_valid", relu_valid, mpop_last);
         if (relu_valid === 1'b1) begin
            if (exp_d.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got data %0d expected no pulse at %0t", relu_data, $time);
            end else begin
               chk("relu_data", relu_data, exp_d.pop_front());
               chk("relu_eol", relu_eol, exp_e.pop_front());
            end
         end else begin
            chk("idle_data", relu_data, 0);
            chk("idle_eol", relu_eol, 0);
         end
      end
   end

   initial begin
      int fill_before;
      bit seen;
      rstn = 1'b0;
      conv_valid = 1'b0;
      conv_data = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_valid", relu_valid, 0);
      chk("rst_data", relu_data, 0);
      chk("rst_eol", relu_eol, 0);
      chk("rst_ovf", ovf_err, 0);
      chk("rst_ready", conv_ready, 1);
      rstn = 1'b1;

      // Single write, one-cycle latency
      step(1'b1, 26'd37);
      step(1'b0, '0);
      chk("lat_valid", relu_valid, 1);
      chk("lat_data", relu_data, 37);
      step(1'b0, '0);
      chk("lat_after", relu_data, 0);
      drain();

      // Saturation corners on consecutive cycles
      step(1'b1, -26'sd5);
      step(1'b1, 26'd4194304);
      step(1'b1, 26'd4194303);
      step(1'b1, 26'd0);
      drain();

      // Row marking over 12 pixels
      for (int i = 0; i < 12; i++) step(1'b1, CONV_W'(100 + i));
      drain();

      // Overflowing burst
      for (int i = 0; i < 28; i++) step(1'b1, CONV_W'(1000 + i));
      chk("burst_ovf", ovf_err, 1);
      drain();
      chk("burst_ovf_sticky", ovf_err, 1);

      // Reset while buffered data and a pulse are in flight
      for (int i = 0; i < 8; i++) step(1'b1, CONV_W'(2000 + i));
      conv_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (relu_valid === 1'b1) seen = 1'b1;
         else step(1'b0, '0);
      end
      chk("mid_rst_pulse_seen", seen, 1);
      fill_before = mq.size();
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", relu_valid, 0);
      chk("mid_rst_data", relu_data, 0);
      chk("mid_rst_ovf", ovf_err, 0);
      model_clear();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, '0);
      if (fill_before < 1) chk("mid_rst_fill", fill_before, 1);

      // Sustained 1-in-GAP writes of small random values
      max_fill = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, CONV_W'($urandom_range(50, 0)));
         repeat (GAP - 1) step(1'b0, '0);
      end
      drain();
      chk("paced_ovf", ovf_err, 0);
      chk("paced_max_fill", (max_fill <= 2), 1);

      // Random validity with full-range signed data
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(1, 0)), CONV_W'($urandom));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
